// File: rtl/row_pkt_pkg.sv
// Shared definitions for the row-data packet link.
// Imported by the request manager (producer) and row_pkt_receiver (consumer).
//  - Beat field offsets for the header/footer layout
//  - Completion error codes
//  - Receiver FSM state encoding
package row_pkt_pkg;

  localparam int unsigned AXIS_DATA_W   = 512;

  localparam int unsigned PKT_TYPE_OFFS = 0;
  localparam int unsigned ROW_RQID_OFFS = 8;
  localparam int unsigned ROW_STAT_OFFS = 40;

  localparam logic [7:0] ERR_TYPE  = 8'd1;
  localparam logic [7:0] ERR_SHORT = 8'd2;
  localparam logic [7:0] ERR_LONG  = 8'd3;
  localparam logic [7:0] ERR_ID    = 8'd4;

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_DATA  = 2'd1,
    S_FTR   = 2'd2,
    S_DRAIN = 2'd3
  } rx_state_e;

endpackage

// File: rtl/axis_skid_512.sv
// 512-bit AXI-Stream output register with a one-entry skid buffer.
// Ports:
//  clk, resetn   clock, synchronous active-low reset
//  i_push        a beat (i_data, i_last) is accepted this cycle
//  o_tdata/o_tvalid/o_tlast/i_tready   downstream AXI-Stream
//  o_skid_full   skid entry occupied; upstream must stop pushing
module axis_skid_512
  import row_pkt_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_push,
  input  logic [AXIS_DATA_W-1:0] i_data,
  input  logic                   i_last,
  output logic [AXIS_DATA_W-1:0] o_tdata,
  output logic                   o_tvalid,
  output logic                   o_tlast,
  input  logic                   i_tready,
  output logic                   o_skid_full
);

  logic [AXIS_DATA_W-1:0] r_out_data;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic [AXIS_DATA_W-1:0] r_skid_data;
  logic                   r_skid_valid;
  logic                   r_skid_last;
  logic                   w_out_free;

  // Output reg can take a new beat when empty or being consumed this cycle.
  assign w_out_free = !r_out_valid || i_tready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_last  <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        // Oldest beat lives in the skid; it moves first to keep order.
        r_out_data  <= r_skid_data;
        r_out_last  <= r_skid_last;
        r_out_valid <= 1'b1;
        if (i_push) begin
          r_skid_data <= i_data;
          r_skid_last <= i_last;
        end else begin
          r_skid_valid <= 1'b0;
        end
      end else if (i_push) begin
        r_out_data  <= i_data;
        r_out_last  <= i_last;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (i_push && !r_skid_valid) begin
      r_skid_data  <= i_data;
      r_skid_last  <= i_last;
      r_skid_valid <= 1'b1;
    end
  end

  assign o_tdata     = r_out_data;
  assign o_tvalid    = r_out_valid;
  assign o_tlast     = r_out_last;
  assign o_skid_full = r_skid_valid;

endmodule

// File: rtl/row_pkt_receiver.sv
// Row-data packet receiver: checks header/data/footer framing, strips header and
// footer, forwards data beats and reports one completion per packet.
// Ports:
//  clk, resetn                 clock, synchronous active-low reset
//  AXIS_RX_*                   incoming packet stream (always ready for hdr/ftr)
//  AXIS_TX_*                   stripped row data, TLAST on last forwarded beat
//  CMPL_VALID/ID/STATUS/ERR    1-cycle completion strobe with held fields
//  ERR_COUNT                   saturating framing-error count
module row_pkt_receiver
  import row_pkt_pkg::*;
#(
  parameter int unsigned REQ_ID_WIDTH     = 32,
  parameter int unsigned BEATS_PER_PACKET = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [AXIS_DATA_W-1:0]  AXIS_RX_TDATA,
  input  logic                    AXIS_RX_TVALID,
  input  logic                    AXIS_RX_TLAST,
  output logic                    AXIS_RX_TREADY,
  output logic [AXIS_DATA_W-1:0]  AXIS_TX_TDATA,
  output logic                    AXIS_TX_TVALID,
  output logic                    AXIS_TX_TLAST,
  input  logic                    AXIS_TX_TREADY,
  output logic                    CMPL_VALID,
  output logic [REQ_ID_WIDTH-1:0] CMPL_ID,
  output logic [7:0]              CMPL_STATUS,
  output logic                    CMPL_ERR,
  output logic [15:0]             ERR_COUNT
);

  localparam logic [7:0] LAST_IDX = 8'(BEATS_PER_PACKET - 1);

  rx_state_e               r_state;
  rx_state_e               w_state_nxt;
  logic [7:0]              r_cnt;
  logic [REQ_ID_WIDTH-1:0] r_hdr_id;
  logic                    r_cmpl_valid;
  logic [REQ_ID_WIDTH-1:0] r_cmpl_id;
  logic [7:0]              r_cmpl_status;
  logic                    r_cmpl_err;
  logic [15:0]             r_err_count;

  logic                    w_rx_hs;
  logic                    w_skid_full;
  logic [7:0]              w_type;
  logic [REQ_ID_WIDTH-1:0] w_id;
  logic [7:0]              w_stat;
  logic                    w_push;
  logic                    w_push_last;
  logic                    w_cmpl_fire;
  logic                    w_cmpl_err;
  logic [7:0]              w_cmpl_code;
  logic [REQ_ID_WIDTH-1:0] w_cmpl_id;

  assign w_type  = AXIS_RX_TDATA[PKT_TYPE_OFFS +: 8];
  assign w_id    = AXIS_RX_TDATA[ROW_RQID_OFFS +: REQ_ID_WIDTH];
  assign w_stat  = AXIS_RX_TDATA[ROW_STAT_OFFS +: 8];

  // Only data beats can be back-pressured; header/footer/drain beats never stall.
  assign AXIS_RX_TREADY = resetn && !(r_state == S_DATA && w_skid_full);
  assign w_rx_hs        = AXIS_RX_TVALID && AXIS_RX_TREADY;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_HDR;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR: begin
        if (w_rx_hs) begin
          if (w_type != 8'h00 || AXIS_RX_TLAST) w_state_nxt = AXIS_RX_TLAST ? S_HDR : S_DRAIN;
          else                                  w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_rx_hs && (AXIS_RX_TLAST || r_cnt == LAST_IDX)) begin
          w_state_nxt = AXIS_RX_TLAST ? S_HDR : S_FTR;
        end
      end
      S_FTR: begin
        if (w_rx_hs) w_state_nxt = AXIS_RX_TLAST ? S_HDR : S_DRAIN;
      end
      S_DRAIN: begin
        if (w_rx_hs && AXIS_RX_TLAST) w_state_nxt = S_HDR;
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  // Output logic: data forwarding and completion events
  always_comb begin
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_cmpl_fire = 1'b0;
    w_cmpl_err  = 1'b0;
    w_cmpl_code = 8'h00;
    w_cmpl_id   = r_hdr_id;
    case (r_state)
      S_HDR: begin
        if (w_rx_hs && (w_type != 8'h00 || AXIS_RX_TLAST)) begin
          // Header not latched yet, so report the ID carried by this beat.
          w_cmpl_fire = 1'b1;
          w_cmpl_err  = 1'b1;
          w_cmpl_code = ERR_TYPE;
          w_cmpl_id   = w_id;
        end
      end
      S_DATA: begin
        if (w_rx_hs) begin
          w_push      = 1'b1;
          w_push_last = AXIS_RX_TLAST || (r_cnt == LAST_IDX);
          if (AXIS_RX_TLAST) begin
            w_cmpl_fire = 1'b1;
            w_cmpl_err  = 1'b1;
            w_cmpl_code = ERR_SHORT;
          end
        end
      end
      S_FTR: begin
        if (w_rx_hs) begin
          w_cmpl_fire = 1'b1;
          w_cmpl_err  = 1'b1;
          if (!AXIS_RX_TLAST)          w_cmpl_code = ERR_LONG;
          else if (w_type != 8'h00)    w_cmpl_code = ERR_TYPE;
          else if (w_id != r_hdr_id)   w_cmpl_code = ERR_ID;
          else begin
            w_cmpl_err  = 1'b0;
            w_cmpl_code = w_stat;
          end
        end
      end
      default: ;
    endcase
  end

  // Counter, header ID and completion registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt         <= 8'h00;
      r_hdr_id      <= '0;
      r_cmpl_valid  <= 1'b0;
      r_cmpl_id     <= '0;
      r_cmpl_status <= 8'h00;
      r_cmpl_err    <= 1'b0;
      r_err_count   <= 16'h0000;
    end else begin
      if (w_rx_hs && r_state == S_HDR) begin
        r_hdr_id <= w_id;
        r_cnt    <= 8'h00;
      end else if (w_rx_hs && r_state == S_DATA) begin
        r_cnt <= r_cnt + 8'd1;
      end
      r_cmpl_valid <= w_cmpl_fire;
      if (w_cmpl_fire) begin
        r_cmpl_id     <= w_cmpl_id;
        r_cmpl_status <= w_cmpl_code;
        r_cmpl_err    <= w_cmpl_err;
        if (w_cmpl_err && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  axis_skid_512 u_skid (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_push),
    .i_data      (AXIS_RX_TDATA),
    .i_last      (w_push_last),
    .o_tdata     (AXIS_TX_TDATA),
    .o_tvalid    (AXIS_TX_TVALID),
    .o_tlast     (AXIS_TX_TLAST),
    .i_tready    (AXIS_TX_TREADY),
    .o_skid_full (w_skid_full)
  );

  assign CMPL_VALID  = r_cmpl_valid;
  assign CMPL_ID     = r_cmpl_id;
  assign CMPL_STATUS = r_cmpl_status;
  assign CMPL_ERR    = r_cmpl_err;
  assign ERR_COUNT   = r_err_count;

endmodule
